// File: rtl/jt49_eg_multi.sv
// Multi-channel AY-3-8910 / YM2149 style envelope generator with per-channel period counters.
// Latency: one cen from a gain/inv change to env_o; done_o follows the internal stop flag one cen later.
// Backpressure: none. The block free-runs on cen_i, and every output is a registered level or a one-clk pulse.
//
// Ports:
//   clk_i, rst_i    clock and asynchronous active-high reset
//   cen_i           clock enable; state only advances on edges with cen_i=1
//   restart_i[CH]   per-channel shape restart, sampled on cen
//   ctrl_i[4*CH]    per-channel {CONT,ATT,ALT,HOLD}; channel n at [4n+3:4n]
//   period_i        per-channel period in cen ticks; channel n at [PER_W*n +: PER_W]
//   env_o           per-channel envelope level; packed in the same way as period_i
//   done_o[CH]      channel is stopped in its hold state
//   step_out_o[CH]  one-clk pulse when the channel's period counter wraps
module jt49_eg_multi #(
  parameter int CH    = 3,
  parameter int ENV_W = 5,
  parameter int PER_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cen_i,
  input  logic [CH-1:0]       restart_i,
  input  logic [4*CH-1:0]     ctrl_i,
  input  logic [PER_W*CH-1:0] period_i,
  output logic [ENV_W*CH-1:0] env_o,
  output logic [CH-1:0]       done_o,
  output logic [CH-1:0]       step_out_o
);

  localparam logic [ENV_W-1:0] MAX = '1;

  for (genvar n = 0; n < CH; n++) begin : g_ch
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic [ENV_W-1:0] gain_q, gain_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic             inv_q, inv_d;
    logic             stop_q, stop_d;
    logic             done_q, done_d;
    logic             step_q, step_d;

    logic [PER_W-1:0] per, eff;
    logic             cont, att, alt, hold;
    logic             wrap, will_hold, flip;

    assign {cont, att, alt, hold} = ctrl_i[4*n +: 4];
    assign per  = period_i[PER_W*n +: PER_W];
    // A zero period behaves like a period of one.
    assign eff  = (per == '0) ? PER_W'(1) : per;
    // ">=" rather than "==" so that shrinking the period below the running
    // count forces a wrap instead of waiting for the counter to roll over.
    assign wrap = (cnt_q >= (eff - PER_W'(1)));
    assign will_hold = ~cont | hold;
    // Direction flips at the end of a ramp for one-shot rising shapes
    // (so they finish at 0) and for alternating continuous shapes.
    assign flip = (~cont & att) | (cont & alt);

    always_comb begin
      cnt_d  = cnt_q;
      gain_d = gain_q;
      inv_d  = inv_q;
      stop_d = stop_q;
      env_d  = env_q;
      done_d = done_q;
      step_d = 1'b0;
      if (cen_i) begin
        env_d  = inv_q ? ~gain_q : gain_q;
        done_d = stop_q;
        if (restart_i[n]) begin
          cnt_d  = '0;
          gain_d = MAX;
          inv_d  = att;
          stop_d = 1'b0;
        end else if (wrap) begin
          cnt_d  = '0;
          step_d = 1'b1;
          // Once stopped, the counter keeps running and step still pulses,
          // but gain and inv are frozen.
          if (!stop_q) begin
            if (gain_q != '0) begin
              gain_d = gain_q - ENV_W'(1);
            end else begin
              if (will_hold) begin
                stop_d = 1'b1;
              end else begin
                gain_d = MAX;
              end
              if (flip) begin
                inv_d = ~inv_q;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + PER_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q  <= '0;
        gain_q <= MAX;
        inv_q  <= 1'b0;
        stop_q <= 1'b0;
        env_q  <= '0;
        done_q <= 1'b0;
        step_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        gain_q <= gain_d;
        inv_q  <= inv_d;
        stop_q <= stop_d;
        env_q  <= env_d;
        done_q <= done_d;
        step_q <= step_d;
      end
    end

    assign env_o[ENV_W*n +: ENV_W] = env_q;
    assign done_o[n]               = done_q;
    assign step_out_o[n]           = step_q;
  end

endmodule

// File: tb/tb_jt49_eg_multi.sv
// Scoreboard bench for jt49_eg_multi: the driver pushes the expected outputs of
// every clock edge into a queue, and a monitor pops and compares on the falling edge.
module tb_jt49_eg_multi;
  localparam int CH    = 3;
  localparam int ENV_W = 5;
  localparam int PER_W = 16;
  localparam int MAXV  = (1 << ENV_W) - 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cen = 1'b0;
  logic [CH-1:0]       restart = '0;
  logic [4*CH-1:0]     ctrl = '0;
  logic [PER_W*CH-1:0] period = '0;
  logic [ENV_W*CH-1:0] env;
  logic [CH-1:0]       done;
  logic [CH-1:0]       step_out;

  jt49_eg_multi #(.CH(CH), .ENV_W(ENV_W), .PER_W(PER_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cen_i      (cen),
    .restart_i  (restart),
    .ctrl_i     (ctrl),
    .period_i   (period),
    .env_o      (env),
    .done_o     (done),
    .step_out_o (step_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ENV_W*CH-1:0] env;
    logic [CH-1:0]       done;
    logic [CH-1:0]       step;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: a level walking up or down a ramp, plus a tick counter.
  int                  lvl  [CH];
  int                  dir  [CH];
  int                  tcnt [CH];
  bit                  held [CH];
  logic [ENV_W*CH-1:0] env_e;
  logic [CH-1:0]       done_e;
  logic [CH-1:0]       step_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < CH; n++) begin
      lvl[n] = MAXV; dir[n] = -1; tcnt[n] = 0; held[n] = 0;
    end
    env_e = '0; done_e = '0; step_e = '0;
  endtask

  task automatic model_edge();
    if (!cen) begin
      step_e = '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        bit c_, a_, al_, h_, tg;
        int e_, endv;
        c_  = ctrl[4*n+3]; a_ = ctrl[4*n+2]; al_ = ctrl[4*n+1]; h_ = ctrl[4*n];
        env_e[ENV_W*n +: ENV_W] = ENV_W'(lvl[n]);
        done_e[n] = held[n];
        if (restart[n]) begin
          tcnt[n] = 0; held[n] = 0; step_e[n] = 1'b0;
          lvl[n] = a_ ? 0 : MAXV;
          dir[n] = a_ ? 1 : -1;
        end else begin
          e_ = int'(period[PER_W*n +: PER_W]);
          if (e_ == 0) e_ = 1;
          if (tcnt[n] >= e_ - 1) begin
            tcnt[n] = 0; step_e[n] = 1'b1;
            if (!held[n]) begin
              endv = (dir[n] > 0) ? MAXV : 0;
              tg   = c_ ? al_ : a_;
              if (lvl[n] != endv) begin
                lvl[n] += dir[n];
              end else if (!c_ || h_) begin
                held[n] = 1;
                if (tg) lvl[n] = MAXV - lvl[n];
              end else if (tg) begin
                dir[n] = -dir[n];
              end else begin
                lvl[n] = (dir[n] > 0) ? 0 : MAXV;
              end
            end
          end else begin
            tcnt[n]++; step_e[n] = 1'b0;
          end
        end
      end
    end
  endtask

  // Inputs are set on the falling edge; the model advances at the rising edge.
  task automatic tick(input bit c);
    exp_t e;
    cen = c;
    @(posedge clk);
    model_edge();
    e.env = env_e; e.done = done_e; e.step = step_e;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("env",      64'(env),      64'(e.env));
        chk("done",     64'(done),     64'(e.done));
        chk("step_out", 64'(step_out), 64'(e.step));
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("reset_env",  64'(env),      64'd0);
    chk("reset_done", 64'(done),     64'd0);
    chk("reset_step", 64'(step_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // First cen after reset shows MAX on every channel.
    tick(1'b1);

    // Falling one-shot, triangle rising, falling-then-hold-MAX.
    ctrl   = {4'b1011, 4'b1110, 4'b0000};
    period = {16'd3, 16'd2, 16'd1};
    restart = 3'b111;
    tick(1'b1);
    restart = '0;
    repeat (150) tick(1'b1);

    // cen gaps: step_out must stay one clk wide.
    for (int i = 0; i < 30; i++) tick(i[0] | i[2]);

    // Restart clears a hold, and ramp starts again.
    restart = 3'b100;
    tick(1'b1);
    restart = '0;
    repeat (20) tick(1'b1);

    // Period 0 on ch0, long period shrunk mid-count on ch1.
    ctrl[3:0] = 4'b0000; ctrl[7:4] = 4'b1000;
    period[PER_W*0 +: PER_W] = 16'd0;
    period[PER_W*1 +: PER_W] = 16'd100;
    restart = 3'b011;
    tick(1'b1);
    restart = '0;
    repeat (50) tick(1'b1);
    period[PER_W*1 +: PER_W] = 16'd3;
    repeat (12) tick(1'b1);

    // Restart coinciding with a wrap on ch0 (period 1 wraps every cen), then held high.
    ctrl[3:0] = 4'b1100;
    period[PER_W*0 +: PER_W] = 16'd1;
    repeat (5) tick(1'b1);
    restart = 3'b001;
    repeat (4) tick(1'b1);
    restart = '0;
    repeat (6) tick(1'b1);

    // Asynchronous reset mid-ramp, with no clock edge in between.
    #1 rst = 1'b1;
    #1;
    chk("async_rst_env",  64'(env),      64'd0);
    chk("async_rst_done", 64'(done),     64'd0);
    chk("async_rst_step", 64'(step_out), 64'd0);
    #1 rst = 1'b0;
    model_reset();
    repeat (3) tick(1'b1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < CH; n++) begin
        restart[n] = ($urandom_range(39) == 0);
        if ($urandom_range(199) == 0) ctrl[4*n +: 4] = 4'($urandom_range(15));
        if ($urandom_range(149) == 0) period[PER_W*n +: PER_W] = PER_W'($urandom_range(4));
      end
      tick($urandom_range(3) != 0);
    end
    restart = '0;
    repeat (2) tick(1'b0);

    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt49_eg_multi.md
Name: jt49_eg_multi

Overview:
Multi-channel, parametrised AY-3-8910-style envelope generator for the jt49 PSG core.
- Each of CH channels has its own envelope period counter, 4-bit shape control, restart and gain state.
- The step timing is generated internally, so no external step strobe is needed.
- Output resolution (ENV_W), period width (PER_W) and channel count are parameters.
- Adds per-channel done flags and step pulses, used by the mixer and by debug logic.

Parameters:
CH, 3, number of independent envelope channels (>=1)
ENV_W, 5, envelope amplitude width in bits (4 = AY native, 5 = YM2149 resolution)
PER_W, 16, envelope period register width in bits

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cen  in  1  clock enable; all state advances only on clk edges with cen=1
restart  in  CH  per-channel shape restart; sampled on cen
ctrl  in  4*CH  per-channel shape {CONT,ATT,ALT,HOLD}; channel n occupies bits [4n+3:4n]
period  in  PER_W*CH  per-channel envelope period in cen ticks; channel n occupies bits [PER_W*n +: PER_W]
env  out  ENV_W*CH  registered envelope level per channel, packed like period
done  out  CH  channel is stopped in hold state
step_out  out  CH  one-clk pulse: the channel's period counter wrapped on this cen

Behaviour:
Per-channel state:
- cnt[PER_W], gain[ENV_W], inv, stop.
- MAX = all ones of ENV_W.
- eff = (period==0) ? 1 : period.

Reset (async, rst=1), taking effect immediately:
- cnt=0, gain=MAX, inv=0, stop=0.
- env=0, done=0, step_out=0.

Updates on each clk edge with cen=1, evaluated per channel:
- restart=1: cnt<=0, gain<=MAX, inv<=ATT, stop<=0, step_out<=0. Restart takes priority over any step in the same cen.
- Otherwise, if cnt >= eff-1: wrap = 1, cnt<=0, step_out<=1.
- Otherwise: cnt<=cnt+1, step_out<=0.
- The >= comparison means that lowering period below the current cnt forces a wrap on the next cen.

On wrap with stop=0:
- If gain != 0: gain<=gain-1.
- If gain == 0:
  - When will_hold = !CONT | HOLD: stop<=1 and gain stays 0.
  - Otherwise gain wraps to MAX.
  - In both cases, inv toggles when (!CONT & ATT) | (CONT & ALT).

On wrap with stop=1:
- gain and inv are frozen.
- step_out still pulses.
- cnt keeps running.

Outputs:
- env[n] <= inv ? ~gain : gain on every cen. This gives one cen of latency from a gain/inv change to env.
- done[n] = stop, registered.
- step_out is forced to 0 on clk edges with cen=0, so it is exactly one clk wide.
- A restart held high keeps the channel at its start point: env = ATT ? 0 : MAX after one cen.
- A change to ctrl without restart takes effect at the next gain==0 decision only. The inv value already loaded is kept.
- Channels are fully independent; there is no shared counter.

Resulting shapes, with ctrl given as {CONT,ATT,ALT,HOLD}:
- 00xx: falling ramp, then 0.
- 01xx: rising ramp, then 0.
- 1000: repeated falling saw.
- 1001: falling, hold 0.
- 1010: triangle, falling first.
- 1011: falling, hold MAX.
- 1100: repeated rising saw.
- 1101: rising, hold MAX.
- 1110: triangle, rising first.
- 1111: rising, hold 0.

Test Plan:
- Reset: rst=1 -> env=0, done=0, step_out=0 on all channels. After release, one cen with restart=0 -> env=0x1F (ENV_W=5).
- Ch0, ctrl=0000, period=1, restart pulse, then 40 cens -> env steps 1F,1E,...,00 on consecutive cens, then holds 00. done=1 from the cen after the wrap at gain 0. step_out pulses every cen.
- Ch1, ctrl=1110, period=2 -> env 00 to 1F rising, then 1F to 00, continuous. gain changes every 2nd cen, and step_out is a single clk pulse every 2nd cen. done stays 0.
- ENV_W=4, ch2, ctrl=1011, period=3 -> env F..0 (16 levels, 48 cens), then holds F with done=1. A restart then clears done and env returns to F, ramping down again.
- Period edge cases: period=0 -> same as period=1. period=100 with cnt=50, then period changes to 3 -> wrap on the next cen, then a wrap every 3 cens.
- Simultaneity: restart and wrap in the same cen -> restart wins, gain=MAX, no decrement. rst asserted mid-ramp without a clk edge -> env=0 and gain=MAX immediately. Other channels are unaffected by ch0's restart.
